sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 The block SHALL have parameter DB_CYC, default 4, meaning the number of consecutive stable synchronized samples required to accept a button level change (range 2..255).
REQ-002 The block SHALL have parameter AUTO_CYC, default 16, meaning the number of cycles in SET state before an automatic clear (range 2..65535; used only when the configuration macro is defined).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port btn_set, input, 1 bit: raw asynchronous set push-button, active-high, possibly bouncing.
REQ-006 The block SHALL have port btn_rst, input, 1 bit: raw asynchronous reset push-button, active-high, possibly bouncing.
REQ-007 The block SHALL have port S, output, 1 bit: a one-cycle set command to the downstream SR flip-flop.
REQ-008 The block SHALL have port R, output, 1 bit: a one-cycle reset command to the downstream SR flip-flop.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the internal state is SET.
REQ-010 The block SHALL have port conflict, output, 1 bit: a one-cycle flag raised when set and reset requests collide.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Each synchronized button SHALL have a debounce counter that increments while the synchronized level differs from the debounced level and clears to 0 whenever the levels match.
REQ-013 The debounced level SHALL toggle, and the counter clear, on the edge where the counter would reach DB_CYC.
REQ-014 A request SHALL be the one-cycle 0->1 transition of a debounced level; 1->0 transitions SHALL generate nothing.
REQ-015 The block SHALL implement a state machine with two states, CLR (downstream Q = 0) and SET (downstream Q = 1), and SHALL reset into CLR.
REQ-016 In state CLR, a set request with no reset request SHALL assert S for exactly one cycle and move the state to SET.
REQ-017 In state SET, a reset request SHALL assert R for exactly one cycle and move the state to CLR.
REQ-018 A set request in SET, or a reset request in CLR, SHALL be ignored: no pulse and no state change.
REQ-019 When set and reset requests occur in the same cycle, reset SHALL win: R is asserted only if the state is SET, conflict is asserted for one cycle, and the state becomes CLR.
REQ-020 S and R SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-021 Latency: with btn_set held high and clean, S SHALL be high during the cycle following rising edge DB_CYC+2, counted from the first edge that samples btn_set high.
REQ-022 A bounce shorter than DB_CYC cycles SHALL produce no request.
REQ-023 busy SHALL equal (state == SET).

Reset
REQ-024 While rst_n = 0, the block SHALL force S = 0, R = 0, conflict = 0, busy = 0, state CLR, clear all synchronizer flops, debounced levels and counters, and clear the auto-clear counter, all asynchronously.
REQ-025 A reset asserted mid-debounce or mid-SET SHALL discard pending progress; after release, a held button SHALL require the full DB_CYC+2 qualification again.
REQ-026 Reset deassertion SHALL be followed by normal operation on the next rising edge of clk.

Configuration
REQ-027 When macro SR_CMD_GEN_AUTO_CLR_EN is defined, a 16-bit counter SHALL count cycles in SET, clearing on entry to SET.
REQ-028 With SR_CMD_GEN_AUTO_CLR_EN defined, on reaching AUTO_CYC the block SHALL assert R for one cycle and return to CLR; a user reset request on that same edge SHALL produce a single R only.
REQ-029 When SR_CMD_GEN_AUTO_CLR_EN is undefined, the counter SHALL be absent and SET SHALL persist until a reset request.

Verification
REQ-030 The bench SHALL cover the following scenario: after reset, hold btn_set high with DB_CYC=4 -> single S pulse in the cycle after edge 6, busy=1, R=0.
REQ-031 The bench SHALL cover the following scenario: btn_set glitches of 1, 2 and 3 cycles -> no S and busy stays 0.
REQ-032 The bench SHALL cover the following scenario: from SET, press btn_set again -> no S; then press btn_rst -> one R, busy=0.
REQ-033 The bench SHALL cover the following scenario: both buttons rise in the same cycle while in SET -> R=1 and conflict=1 for one cycle, S=0, busy=0.
REQ-034 The bench SHALL cover the following scenario: with SR_CMD_GEN_AUTO_CLR_EN defined and AUTO_CYC=16, set and then hold idle -> R pulses 16 cycles after S, busy=0; with the macro undefined, busy stays 1 for 100 cycles.
REQ-035 The bench SHALL cover the following scenario: assert rst_n=0 for 3 cycles midway through a held btn_set -> all outputs 0 immediately, and S appears only DB_CYC+2 edges after release.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// Debounced push-button front end that issues one-cycle S/R commands to a downstream SR flip-flop.
// Optional auto-clear after AUTO_CYC cycles in SET is enabled by defining SR_CMD_GEN_AUTO_CLR_EN.
module sr_cmd_gen #(
    parameter int unsigned DB_CYC   = 4,
    parameter int unsigned AUTO_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    localparam int unsigned NBTN   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned AUTO_W = 16;
    localparam int unsigned IDX_SET = 0;
    localparam int unsigned IDX_RST = 1;

    if (DB_CYC < 2 || DB_CYC > 255 || AUTO_CYC < 2 || AUTO_CYC > 65535) begin : g_param_check
        $error("sr_cmd_gen: DB_CYC or AUTO_CYC out of range");
    end

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_SET = 1'b1
    } state_e;

    logic [NBTN-1:0]            btn_raw;
    logic [NBTN-1:0]            sync1_q;
    logic [NBTN-1:0]            sync2_q;
    logic [NBTN-1:0]            db_q;
    logic [NBTN-1:0]            db_d;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q;
    logic [NBTN-1:0][CNT_W-1:0] cnt_d;
    logic [NBTN-1:0]            req_c;

    state_e state_q;
    state_e state_d;
    logic   s_q;
    logic   s_d;
    logic   r_q;
    logic   r_d;
    logic   conflict_q;
    logic   conflict_d;
    logic   auto_hit_c;

    assign btn_raw = {btn_rst, btn_set};

    // Synchronizers, debounce state and command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            cnt_q      <= '0;
            state_q    <= ST_CLR;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    // A request fires on the same edge the debounced level rises, so S lands one cycle later.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        req_c = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_W'(DB_CYC - 1)) begin
                    db_d[i]  = ~db_q[i];
                    req_c[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef SR_CMD_GEN_AUTO_CLR_EN
    logic [AUTO_W-1:0] auto_q;
    logic [AUTO_W-1:0] auto_d;

    // Counts cycles spent in SET; zero on the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end

    always_comb begin
        auto_d     = (state_q == ST_SET) ? auto_q + AUTO_W'(1) : '0;
        auto_hit_c = (state_q == ST_SET) && (auto_q == AUTO_W'(AUTO_CYC - 1));
    end
`else
    assign auto_hit_c = 1'b0;
`endif

    // Command FSM: reset wins over set; auto-clear merges with a user reset into one R.
    always_comb begin
        state_d    = state_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        if (req_c[IDX_SET] && req_c[IDX_RST]) begin
            conflict_d = 1'b1;
            r_d        = (state_q == ST_SET);
            state_d    = ST_CLR;
        end else if (req_c[IDX_RST] || auto_hit_c) begin
            r_d     = (state_q == ST_SET);
            state_d = ST_CLR;
        end else if (req_c[IDX_SET] && (state_q == ST_CLR)) begin
            s_d     = 1'b1;
            state_d = ST_SET;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign busy     = (state_q == ST_SET);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: stimulus queues expected output pulses with their cycle stamp,
// a monitor pops and compares whenever S, R or conflict is seen high.
module tb_sr_cmd_gen;

    localparam int unsigned DB_CYC   = 4;
    localparam int unsigned AUTO_CYC = 16;
    localparam int unsigned LAT      = DB_CYC + 2;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    int unsigned cyc;
    int          checks;
    int          errors;

    typedef struct {
        logic [3:0]  outs;
        int unsigned at;
    } exp_t;

    exp_t exp_q[$];

    sr_cmd_gen #(
        .DB_CYC  (DB_CYC),
        .AUTO_CYC(AUTO_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_set (btn_set),
        .btn_rst (btn_rst),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .conflict(conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // outs = {S, R, conflict, busy}
    task automatic expect_out(input logic [3:0] outs, input int unsigned at);
        exp_t e;
        e.outs = outs;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every pulse on S, R or conflict must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (S || R || conflict)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'({S, R, conflict, busy}), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", int'(cyc), int'(e.at));
                chk("pulse_outs_SRCB", int'({S, R, conflict, busy}), int'(e.outs));
            end
        end
    end

    initial begin
        int unsigned b;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        btn_set = 1'b0;
        btn_rst = 1'b0;

        wait_until(3);
        chk("rst_S", int'(S), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Short glitches never qualify.
        b = 6;
        for (int n = 1; n <= 3; n++) begin
            wait_until(b);
            btn_set = 1'b1;
            wait_until(b + n);
            btn_set = 1'b0;
            b = b + 12;
        end
        wait_until(b);
        chk("glitch_busy", int'(busy), 0);

        // Held btn_set: single S after LAT edges.
        b = b + 2;
        wait_until(b);
        btn_set = 1'b1;
        expect_out(4'b1001, b + LAT);
        wait_until(b + 7);
        chk("set_busy", int'(busy), 1);
        chk("set_R", int'(R), 0);
        chk("set_single_S", int'(S), 0);
        btn_set = 1'b0;

        // Set again in SET is ignored; reset press gives one R.
        wait_until(b + 14);
        btn_set = 1'b1;
        wait_until(b + 15);
        btn_rst = 1'b1;
        expect_out(4'b0100, b + 15 + LAT);
        wait_until(b + 18);
        btn_set = 1'b0;
        wait_until(b + 19);
        btn_rst = 1'b0;
        wait_until(b + 22);
        chk("rst_busy_after_R", int'(busy), 0);
        wait_until(b + 30);
        chk("ignored_set_busy", int'(busy), 0);

        // Simultaneous set and reset while in SET.
        b = b + 40;
        wait_until(b);
        btn_set = 1'b1;
        expect_out(4'b1001, b + LAT);
        wait_until(b + 7);
        btn_set = 1'b0;
        wait_until(b + 14);
        btn_set = 1'b1;
        btn_rst = 1'b1;
        expect_out(4'b0110, b + 14 + LAT);
        wait_until(b + 20);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        wait_until(b + 22);
        chk("conflict_busy", int'(busy), 0);

        // Set then idle: auto-clear or persistent SET.
        b = b + 40;
        wait_until(b);
        btn_set = 1'b1;
        expect_out(4'b1001, b + LAT);
        wait_until(b + 5);
        btn_set = 1'b0;
`ifdef SR_CMD_GEN_AUTO_CLR_EN
        expect_out(4'b0100, b + LAT + AUTO_CYC);
        wait_until(b + LAT + AUTO_CYC - 1);
        chk("auto_busy_before", int'(busy), 1);
        wait_until(b + LAT + AUTO_CYC + 2);
        chk("auto_busy_after", int'(busy), 0);
`else
        for (int k = 0; k < 100; k++) begin
            wait_until(b + LAT + 1 + k);
            chk("hold_busy", int'(busy), 1);
        end
        wait_until(b + 110);
        btn_rst = 1'b1;
        expect_out(4'b0100, b + 110 + LAT);
        wait_until(b + 115);
        btn_rst = 1'b0;
        wait_until(b + 118);
        chk("hold_busy_cleared", int'(busy), 0);
`endif

        // Reset during SET with btn_set still held: full requalification after release.
        b = b + 140;
        wait_until(b);
        btn_set = 1'b1;
        expect_out(4'b1001, b + LAT);
        wait_until(b + 10);
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_S", int'(S), 0);
        chk("async_rst_R", int'(R), 0);
        chk("async_rst_conflict", int'(conflict), 0);
        chk("async_rst_busy", int'(busy), 0);
        wait_until(b + 13);
        rst_n = 1'b1;
        expect_out(4'b1001, b + 13 + LAT);
`ifdef SR_CMD_GEN_AUTO_CLR_EN
        expect_out(4'b0100, b + 13 + LAT + AUTO_CYC);
`endif
        wait_until(b + 13 + LAT - 1);
        chk("requal_busy_early", int'(busy), 0);
        wait_until(b + 13 + LAT + 1);
        chk("requal_busy", int'(busy), 1);
        wait_until(b + 25);
        btn_set = 1'b0;

        wait_until(b + 50);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
